fir_decim_rx: RTL and testbench



---
 rtl/fir_decim_rx.sv | 123 ++++++++++++
 tb/tb_fir_decim_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_rx.sv
// Receive-side matched 9-tap symmetric FIR with decimation by DECIM and a serial folded MAC.
// Build option: define FIR_RX_ROUND_EN for round-half-up output scaling; otherwise the result is truncated.
module fir_decim_rx #(
    parameter int DW_IN  = 18,
    parameter int DW_OUT = 18,
    parameter int DECIM  = 2,
    parameter int C0     = 7,
    parameter int C1     = 17,
    parameter int C2     = 32,
    parameter int C3     = 46,
    parameter int C4     = 52,
    parameter int SHIFT  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW_IN-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DW_OUT-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam int ACC_W = DW_IN + SHIFT + 1;
    localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;

`ifdef FIR_RX_ROUND_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);
`else
    localparam logic [ACC_W-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [DW_IN-1:0]   x_reg [9];
    logic [PW-1:0]      phase_reg;
    logic [2:0]         k_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [7:0]         coef;
    logic [DW_IN:0]     pair;
    logic [ACC_W-1:0]   acc_sum;
    logic               accept;
    logic               decim_hit;

    assign din_ready = reset && (state_reg == IDLE);
    assign accept    = din_valid && din_ready;
    assign decim_hit = (phase_reg == PW'(DECIM - 1));

    // Folded tap: symmetric pairs share one coefficient, the centre tap stands alone.
    always_comb begin
        coef = '0;
        pair = '0;
        case (k_reg)
            3'd0: begin coef = 8'(C0); pair = {1'b0, x_reg[0]} + {1'b0, x_reg[8]}; end
            3'd1: begin coef = 8'(C1); pair = {1'b0, x_reg[1]} + {1'b0, x_reg[7]}; end
            3'd2: begin coef = 8'(C2); pair = {1'b0, x_reg[2]} + {1'b0, x_reg[6]}; end
            3'd3: begin coef = 8'(C3); pair = {1'b0, x_reg[3]} + {1'b0, x_reg[5]}; end
            3'd4: begin coef = 8'(C4); pair = {1'b0, x_reg[4]}; end
            default: begin coef = '0; pair = '0; end
        endcase
        acc_sum = acc_reg + (ACC_W'(coef) * ACC_W'(pair));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept && decim_hit) state_next = MAC;
            MAC:  if (k_reg == 3'd4) state_next = OUT;
            OUT:  if (dout_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) begin
                x_reg[i] <= '0;
            end
            phase_reg  <= '0;
            k_reg      <= '0;
            acc_reg    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (accept) begin
                x_reg[0] <= din;
                for (int i = 1; i < 9; i++) begin
                    x_reg[i] <= x_reg[i-1];
                end
                if (decim_hit) begin
                    phase_reg <= '0;
                    k_reg     <= '0;
                    acc_reg   <= '0;
                end else begin
                    phase_reg <= phase_reg + PW'(1);
                end
            end
            // The delay line is frozen during MAC because din_ready is low.
            if (state_reg == MAC) begin
                k_reg   <= k_reg + 3'd1;
                acc_reg <= acc_sum;
                if (k_reg == 3'd4) begin
                    dout       <= DW_OUT'((acc_sum + RND) >> SHIFT);
                    dout_valid <= 1'b1;
                end
            end
            if (state_reg == OUT && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_decim_rx.sv
// Directed bench for fir_decim_rx: one DECIM=1 instance and one DECIM=2 instance.
module tb_fir_decim_rx;

    logic        clk = 1'b0;
    logic        reset_a      [2];
    logic [17:0] din_a        [2];
    logic        din_valid_a  [2];
    logic        din_ready_a  [2];
    logic [17:0] dout_a       [2];
    logic        dout_valid_a [2];
    logic        dout_ready_a [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_decim_rx #(.DECIM(1)) u_d1 (
        .clk(clk), .reset(reset_a[0]),
        .din(din_a[0]), .din_valid(din_valid_a[0]), .din_ready(din_ready_a[0]),
        .dout(dout_a[0]), .dout_valid(dout_valid_a[0]), .dout_ready(dout_ready_a[0])
    );

    fir_decim_rx #(.DECIM(2)) u_d2 (
        .clk(clk), .reset(reset_a[1]),
        .din(din_a[1]), .din_valid(din_valid_a[1]), .din_ready(din_ready_a[1]),
        .dout(dout_a[1]), .dout_valid(dout_valid_a[1]), .dout_ready(dout_ready_a[1])
    );

    typedef struct {
        logic [17:0] din;
        int          exp;
    } vec_t;

    vec_t imp_tab [12];
    vec_t rnd_tab [9];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic do_reset(input int u);
        @(negedge clk);
        reset_a[u] = 1'b0;
        repeat (2) @(negedge clk);
        reset_a[u] = 1'b1;
    endtask

    // Send one sample, then watch up to 8 edges for a resulting output.
    task automatic feed(input int u, input logic [17:0] d,
                        output bit got, output int dv, output int lat);
        int n;
        got = 1'b0;
        dv  = 0;
        lat = 0;
        @(negedge clk);
        din_a[u]       = d;
        din_valid_a[u] = 1'b1;
        n = 0;
        while (!din_ready_a[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("din_ready_wait", int'(n < 20), 1);
        @(posedge clk);
        #1 din_valid_a[u] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (dout_valid_a[u]) begin
                got = 1'b1;
                dv  = int'(dout_a[u]);
                break;
            end
        end
    endtask

    initial begin
        bit got;
        int dv;
        int lat;
        int outs;
        int n;

        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int dv;
        int lat;
        int outs;
        int n;

        imp_tab[0] = '{18'd256, 7};
        imp_tab[1] = '{18'd0, 17};
        imp_tab[2] = '{18'd0, 32};
        imp_tab[3] = '{18'd0, 46};
        imp_tab[4] = '{18'd0, 52};
        imp_tab[5] = '{18'd0, 46};
        imp_tab[6] = '{18'd0, 32};
        imp_tab[7] = '{18'd0, 17};
        imp_tab[8] = '{18'd0, 7};
        imp_tab[9] = '{18'd0, 0};
        imp_tab[10] = '{18'd0, 0};
        imp_tab[11] = '{18'd0, 0};

        // Products 21,51,96,138,156,138,96,51,21: only >=128 round up to 1.
        rnd_tab[0] = '{18'd3, 0};
        for (int i = 1; i < 9; i++) rnd_tab[i] = '{18'd0, 0};
`ifdef FIR_RX_ROUND_EN
        rnd_tab[3].exp = 1;
        rnd_tab[4].exp = 1;
        rnd_tab[5].exp = 1;
`endif

        for (int u = 0; u < 2; u++) begin
            reset_a[u]      = 1'b0;
            din_a[u]        = '0;
            din_valid_a[u]  = 1'b0;
            dout_ready_a[u] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_dout", int'(dout_a[u]), 0);
            check("rst_dout_valid", int'(dout_valid_a[u]), 0);
            check("rst_din_ready", int'(din_ready_a[u]), 0);
        end
        reset_a[0] = 1'b1;
        reset_a[1] = 1'b1;
        @(negedge clk);
        check("din_ready_after_rst", int'(din_ready_a[0]), 1);

        // Impulse, DECIM=1
        for (int i = 0; i < 12; i++) begin
            feed(0, imp_tab[i].din, got, dv, lat);
            check("imp_valid", int'(got), 1);
            check("imp_latency", lat, 5);
            check($sformatf("imp_dout[%0d]", i), dv, imp_tab[i].exp);
        end

        // Rounding at small amplitude
        do_reset(0);
        for (int i = 0; i < 9; i++) begin
            feed(0, rnd_tab[i].din, got, dv, lat);
            check($sformatf("rnd_dout[%0d]", i), dv, rnd_tab[i].exp);
        end

        // DC and full scale, DECIM=2: one output per two accepts
        for (int pass = 0; pass < 2; pass++) begin
            int level;
            level = (pass == 0) ? 1000 : 262143;
            do_reset(1);
            outs = 0;
            for (int i = 0; i < 20; i++) begin
                feed(1, 18'(level), got, dv, lat);
                check("decim_output_phase", int'(got), i % 2);
                if (got) begin
                    outs++;
                    check("decim_latency", lat, 5);
                    if (i >= 9) check($sformatf("settled_%0d", level), dv, level);
                end
            end
            check("decim_output_count", outs, 10);
        end

        // Backpressure: hold dout_ready low for 10 cycles on the first output
        do_reset(0);
        dout_ready_a[0] = 1'b0;
        feed(0, 18'd256, got, dv, lat);
        check("bp_valid", int'(got), 1);
        check("bp_dout", dv, 7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_dout", int'(dout_a[0]), 7);
            check("bp_hold_valid", int'(dout_valid_a[0]), 1);
            check("bp_hold_din_ready", int'(din_ready_a[0]), 0);
        end
        dout_ready_a[0] = 1'b1;
        @(negedge clk);
        check("bp_release_valid", int'(dout_valid_a[0]), 0);
        check("bp_release_din_ready", int'(din_ready_a[0]), 1);
        check("bp_release_dout_kept", int'(dout_a[0]), 7);
        for (int i = 1; i < 4; i++) begin
            feed(0, 18'd0, got, dv, lat);
            check($sformatf("bp_next_dout[%0d]", i), dv, imp_tab[i].exp);
        end

        // Reset asserted while the MAC is at k=2
        @(negedge clk);
        din_a[0]       = 18'd5;
        din_valid_a[0] = 1'b1;
        n = 0;
        while (!din_ready_a[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 din_valid_a[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_a[0] = 1'b0;
        #1;
        check("midmac_rst_dout", int'(dout_a[0]), 0);
        check("midmac_rst_valid", int'(dout_valid_a[0]), 0);
        check("midmac_rst_din_ready", int'(din_ready_a[0]), 0);
        @(negedge clk);
        check("midmac_rst_hold_ready", int'(din_ready_a[0]), 0);
        reset_a[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            feed(0, imp_tab[i].din, got, dv, lat);
            check($sformatf("post_rst_imp[%0d]", i), dv, imp_tab[i].exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
